// File: rtl/uart_pkg.sv
// Shared UART definitions: default clock/line rates and the FSM state encoding.
// No logic; types and constants only.
// Used by both the transmit and receive state machines.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 115200;

  // Both FSMs walk the same four phases of an 8N1 frame.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Divider producing a one-cycle tick every DIV clocks.
// Tick is combinational from the counter; i_clr restarts the period on the next edge.
// No backpressure; runs continuously.
module uart_baud_gen #(
  parameter int unsigned DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(DIV - 1));

  // Count 0..DIV-1 and wrap; a clear realigns the period to the caller's event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart.sv
// 8N1 full-duplex UART: byte serialiser on tx, 16x-oversampled deserialiser on rx.
// TX: tx_busy and start bit one cycle after accepted wr_en, frame 10*TX_DIV clocks; RX: rdy after mid stop bit.
// wr_en ignored while tx_busy; received bytes overwrite dout with no overrun indication.
module uart
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic       rdy,
  input  logic       rdy_clr,
  output logic [7:0] dout
);

  localparam int unsigned TX_DIV = CLK_FREQ / BAUD;
  localparam int unsigned RX_DIV = CLK_FREQ / (16 * BAUD);

  // ---------------- transmitter ----------------
  state_t     r_tx_state, w_tx_state_nxt;
  logic [2:0] r_tx_bit, w_tx_bit_nxt;
  logic [7:0] r_tx_shift, w_tx_shift_nxt;
  logic       r_tx, w_tx_nxt;
  logic       w_tx_tick, w_tx_clr;

  uart_baud_gen #(.DIV(TX_DIV)) u_tx_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_tx_clr),
    .o_tick (w_tx_tick)
  );

  assign tx      = r_tx;
  assign tx_busy = (r_tx_state != IDLE);

  // TX state register; reset drives the line idle-high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= IDLE;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  // TX next state: the bit divider is restarted on acceptance so every bit is exactly TX_DIV clocks.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_nxt       = r_tx;
    w_tx_clr       = 1'b0;
    case (r_tx_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (wr_en) begin
          w_tx_state_nxt = START;
          w_tx_shift_nxt = din;
          w_tx_nxt       = 1'b0;
          w_tx_clr       = 1'b1;
        end
      end
      START: begin
        if (w_tx_tick) begin
          w_tx_state_nxt = DATA;
          w_tx_nxt       = r_tx_shift[0];
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          w_tx_bit_nxt   = 3'd0;
        end
      end
      DATA: begin
        if (w_tx_tick) begin
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nxt = STOP;
            w_tx_nxt       = 1'b1;
          end else begin
            w_tx_nxt       = r_tx_shift[0];
            w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
            w_tx_bit_nxt   = r_tx_bit + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_tx_tick) begin
          w_tx_state_nxt = IDLE;
          w_tx_nxt       = 1'b1;
        end
      end
      default: w_tx_state_nxt = IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  logic       r_rx_meta, r_rx_sync;
  state_t     r_rx_state, w_rx_state_nxt;
  logic [3:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0] r_rx_bit, w_rx_bit_nxt;
  logic [7:0] r_rx_shift, w_rx_shift_nxt;
  logic       w_rx_done;
  logic       w_rx_tick;
  logic       r_rdy;
  logic [7:0] r_dout;

  uart_baud_gen #(.DIV(RX_DIV)) u_rx_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (1'b0),
    .o_tick (w_rx_tick)
  );

  assign rdy  = r_rdy;
  assign dout = r_dout;

  // Two-flop synchroniser for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // RX state register plus the host-facing byte/valid pair; a completing byte beats rdy_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rdy      <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      if (w_rx_done) begin
        r_rdy  <= 1'b1;
        r_dout <= r_rx_shift;
      end else if (rdy_clr) begin
        r_rdy <= 1'b0;
      end
    end
  end

  // RX next state: sample counter counts oversample ticks; 8 ticks to mid start bit, then 16 per bit.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_done      = 1'b0;
    case (r_rx_state)
      IDLE: begin
        if (!r_rx_sync) begin
          w_rx_state_nxt = START;
          w_rx_cnt_nxt   = 4'd0;
        end
      end
      START: begin
        if (w_rx_tick) begin
          if (r_rx_cnt == 4'd7) begin
            w_rx_cnt_nxt   = 4'd0;
            w_rx_bit_nxt   = 3'd0;
            w_rx_state_nxt = r_rx_sync ? IDLE : DATA;
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (w_rx_tick) begin
          if (r_rx_cnt == 4'd15) begin
            w_rx_cnt_nxt   = 4'd0;
            w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) begin
              w_rx_state_nxt = STOP;
            end else begin
              w_rx_bit_nxt = r_rx_bit + 3'd1;
            end
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + 4'd1;
          end
        end
      end
      STOP: begin
        if (w_rx_tick) begin
          if (r_rx_cnt == 4'd15) begin
            w_rx_cnt_nxt   = 4'd0;
            w_rx_state_nxt = IDLE;
            w_rx_done      = r_rx_sync;
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + 4'd1;
          end
        end
      end
      default: w_rx_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart.sv
// Randomised scoreboard bench for the 8N1 UART.
// Stimulus pushes expected frames/bytes; independent monitors decode tx and the rdy/dout pair.
// Uses a fast clock so that TX_DIV=64 and RX_DIV=4.
module tb_uart;

  localparam int BAUD     = 115200;
  localparam int CLK_FREQ = 16 * BAUD * 4;
  localparam int TX_DIV   = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * TX_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       wr_en;
  logic       tx;
  logic       tx_busy;
  wire        rx;
  logic       rdy;
  logic       rdy_clr;
  logic [7:0] dout;
  logic       rx_drv;
  logic       loopback;

  assign rx = loopback ? tx : rx_drv;

  uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .wr_en   (wr_en),
    .tx      (tx),
    .tx_busy (tx_busy),
    .rx      (rx),
    .rdy     (rdy),
    .rdy_clr (rdy_clr),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  exp_t       tx_q[$];
  exp_t       rx_q[$];
  int         checks = 0;
  int         fails  = 0;
  int         tx_free = 0;
  logic [7:0] model_dout = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Call just after a negedge: drives one wr_en cycle; the model accepts only when its own frame timer is idle.
  task automatic host_write(input logic [7:0] b, input logic clr);
    exp_t e;
    din     = b;
    wr_en   = 1'b1;
    rdy_clr = clr;
    if (cyc + 1 >= tx_free) begin
      e.b = b;
      e.t = cyc + 1;
      tx_q.push_back(e);
      if (loopback) rx_q.push_back(e);
      tx_free = cyc + 1 + FRAME + 1;
    end
    @(negedge clk);
    wr_en   = 1'b0;
    rdy_clr = 1'b0;
  endtask

  task automatic wait_free();
    while (cyc + 1 < tx_free) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_ok);
    exp_t       e;
    logic [9:0] bits;
    @(negedge clk);
    bits = {stop_ok, b, 1'b0};
    if (stop_ok) begin
      e.b = b;
      e.t = cyc;
      rx_q.push_back(e);
      model_dout = b;
    end
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat ((i == 9 && !stop_ok) ? 40 : TX_DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rdy(input string name);
    int k = 0;
    while (rdy !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(name, rdy, 1'b1);
  endtask

  task automatic clear_rdy();
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
  endtask

  // TX monitor: each busy frame must start on the expected cycle and carry start, data LSB-first, stop.
  initial begin : tx_mon
    exp_t       e;
    logic [9:0] frame;
    logic [9:0] seen;
    logic       busy_seen;
    logic       abort;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_busy === 1'b1) begin
        if (tx_q.size() == 0) begin
          chk("tx_unexpected_frame", tx_busy, 1'b0);
          for (int k = 0; k < 2000 && tx_busy === 1'b1; k++) @(negedge clk);
        end else begin
          e = tx_q.pop_front();
          chk("tx_start_cycle", cyc, e.t);
          frame     = {1'b1, e.b, 1'b0};
          seen      = frame;
          busy_seen = 1'b1;
          abort     = 1'b0;
          for (int k = 0; k < FRAME; k++) begin
            if (k != 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
              abort = 1'b1;
              break;
            end
            if (tx !== frame[k / TX_DIV]) seen[k / TX_DIV] = tx;
            if (tx_busy !== 1'b1) busy_seen = tx_busy;
          end
          if (!abort) begin
            for (int i = 0; i < 10; i++)
              chk($sformatf("tx_frame_%02h_bit%0d", e.b, i), seen[i], frame[i]);
            chk("tx_busy_held", busy_seen, 1'b1);
            @(negedge clk);
            if (rst_n === 1'b1) begin
              chk("tx_busy_fall", tx_busy, 1'b0);
              chk("tx_idle_high", tx, 1'b1);
            end
          end
        end
      end
    end
  end

  // RX monitor: every rising rdy must carry the next expected byte, shortly after the stop bit's middle.
  initial begin : rx_mon
    exp_t e;
    logic prev = 1'b0;
    int   off;
    forever begin
      @(negedge clk);
      if (rdy === 1'b1 && !prev) begin
        if (rx_q.size() == 0) begin
          chk("rx_unexpected_rdy", rdy, 1'b0);
        end else begin
          e = rx_q.pop_front();
          chk($sformatf("rx_dout_%02h", e.b), dout, e.b);
          off = cyc - e.t;
          checks++;
          if (off < FRAME - 40 || off > FRAME + 10) begin
            fails++;
            $display("FAIL rx_rdy_timing: rdy %0d cycles after frame start, required %0d..%0d",
                     off, FRAME - 40, FRAME + 10);
          end
        end
      end
      prev = (rdy === 1'b1);
    end
  end

  initial begin : watchdog
    #(4_000_000);
    fails++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : stim
    logic [7:0] lb[4];
    rst_n    = 1'b0;
    din      = 8'h00;
    wr_en    = 1'b0;
    rdy_clr  = 1'b0;
    rx_drv   = 1'b1;
    loopback = 1'b0;

    // Reset values, then unchanged while idle after release.
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_tx_busy", tx_busy, 1'b0);
    chk("reset_rdy", rdy, 1'b0);
    chk("reset_dout", dout, 8'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_tx", tx, 1'b1);
    chk("idle_tx_busy", tx_busy, 1'b0);
    chk("idle_rdy", rdy, 1'b0);
    chk("idle_dout", dout, 8'h00);

    // TX 0xA5 with an ignored mid-frame request.
    host_write(8'hA5, 1'b0);
    repeat (300) @(negedge clk);
    host_write(8'hFF, 1'b0);
    wait_free();

    // Random TX bytes, some issued on the first idle cycle.
    for (int i = 0; i < 3; i++) begin
      wait_free();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      host_write(8'($urandom), 1'b0);
    end
    wait_free();
    repeat (4) @(negedge clk);

    // RX 0x3C and the rdy handshake.
    rx_frame(8'h3C, 1'b1);
    wait_rdy("rx_3c_rdy");
    repeat (50) @(negedge clk);
    chk("rdy_held", rdy, 1'b1);
    clear_rdy();
    chk("rdy_cleared", rdy, 1'b0);

    // Random RX bytes.
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      rx_frame(8'($urandom), 1'b1);
      wait_rdy("rx_rand_rdy");
      clear_rdy();
    end

    // Glitch: two oversample ticks of low.
    rx_drv = 1'b0;
    repeat (2 * CLK_FREQ / (16 * BAUD)) @(negedge clk);
    rx_drv = 1'b1;
    repeat (700) @(negedge clk);
    chk("glitch_no_rdy", rdy, 1'b0);

    // Framing error: stop bit sampled low.
    rx_frame(8'h96, 1'b0);
    repeat (200) @(negedge clk);
    chk("framing_no_rdy", rdy, 1'b0);
    chk("framing_dout_kept", dout, model_dout);

    // Loopback, back-to-back; rdy_clr rides with the next wr_en.
    loopback = 1'b1;
    lb[0] = 8'h00;
    lb[1] = 8'hFF;
    lb[2] = 8'h41;
    lb[3] = 8'($urandom);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wait_free();
      if (i != 0) chk("lb_rdy_before_clr", rdy, 1'b1);
      host_write(lb[i], i != 0);
      if (i != 0) chk("lb_rdy_cleared", rdy, 1'b0);
    end
    wait_free();
    wait_rdy("lb_last_rdy");
    clear_rdy();
    loopback = 1'b0;
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of a frame, then a clean frame.
    host_write(8'hC3, 1'b0);
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_reset_tx", tx, 1'b1);
    chk("midframe_reset_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    tx_free = 0;
    repeat (5) @(negedge clk);
    host_write(8'h5A, 1'b0);
    wait_free();
    repeat (4) @(negedge clk);

    for (int k = 0; k < 2000 && (tx_q.size() != 0 || rx_q.size() != 0); k++) @(negedge clk);
    chk("tx_queue_drained", tx_q.size(), 0);
    chk("rx_queue_drained", rx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
